mem_responder: RTL and testbench

Memory responder (slave end) of the valid/ready memory bus: accepts one read or write request from the initiator, waits a fixed number of wait states, completes with a one-cycle `ready` pulse and returns read data on `rdata`. Sits behind the bus as the storage model/target that the initiator BFM drives; holds `DEPTH` words of `WIDTH` bits.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_array.sv | 55 +++++
 rtl/mem_responder.sv | 116 +++++++++++
 tb/tb_mem_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared constants and types for the memory responder slice.
//   DEPTH / WIDTH / ADDR_WIDTH : default geometry of the responder storage
//   CNT_W                      : width of the wait-state counter (0..15)
//   WR / RD                    : encoding of the wr_rd request bit
//   resp_state_t               : responder FSM states
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int DEPTH      = 256;
  localparam int WIDTH      = 16;
  localparam int ADDR_WIDTH = 8;
  localparam int CNT_W      = 4;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Valid/ready memory bus between an initiator and the memory responder.
//   addr   : word address                 (initiator -> responder)
//   wdata  : write data                   (initiator -> responder)
//   wr_rd  : 1 = write, 0 = read          (initiator -> responder)
//   valid  : request present, held until ready seen
//   rdata  : read data, valid with ready on a read (responder -> initiator)
//   ready  : one-cycle completion pulse   (responder -> initiator)
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface mem_responder_if #(
  parameter int WIDTH      = mem_pkg::WIDTH,
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic                  wr_rd;
  logic                  valid;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;

  modport master (
    output addr, wdata, wr_rd, valid,
    input  rdata, ready
  );

  modport slave (
    input  addr, wdata, wr_rd, valid,
    output rdata, ready
  );

endinterface

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// DEPTH x WIDTH storage with one synchronous write port and one registered
// read port with enable. Storage is never reset (contents survive rst); only
// the read data register is cleared by the asynchronous active-low reset.
//   clk   : clock
//   rst   : asynchronous active-low reset (read register only)
//   we    : write enable, writes wdata to addr on posedge
//   re    : read enable, loads rdata from addr on posedge
//   addr  : shared read/write word address
//   wdata : write data
//   rdata : registered read data, holds until the next enabled read
// ---------------------------------------------------------------------------
module mem_array #(
  parameter int DEPTH      = mem_pkg::DEPTH,
  parameter int WIDTH      = mem_pkg::WIDTH,
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Slave end of the valid/ready memory bus. Captures one request in IDLE,
// idles WAIT_STATES cycles, then completes with a one-cycle ready pulse;
// reads return data on rdata, which holds until the next read completes.
//   clk : clock, all logic on posedge
//   rst : asynchronous active-low reset (storage contents are retained)
//   bus : mem_responder_if slave modport (addr, wdata, wr_rd, valid in;
//         rdata, ready out - both registered)
// Parameters: DEPTH, WIDTH, ADDR_WIDTH (2**ADDR_WIDTH == DEPTH),
//             WAIT_STATES (0..15).
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH       = mem_pkg::DEPTH,
  parameter int WIDTH       = mem_pkg::WIDTH,
  parameter int ADDR_WIDTH  = mem_pkg::ADDR_WIDTH,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  import mem_pkg::*;

  resp_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  wr_rd_q, wr_rd_d;
  logic                  ready_q, ready_d;
  logic                  resp_enter;
  logic                  mem_we;
  logic                  mem_re;

  // A captured request always spends at least one cycle in WAIT: the array
  // is addressed from addr_q, which only becomes valid on the capture edge.
  // With WAIT_STATES=0 that WAIT cycle is the single cycle before RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_rd_d    = wr_rd_q;
    ready_d    = 1'b0;
    resp_enter = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          wr_rd_d = bus.wr_rd;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          resp_enter = 1'b1;
          ready_d    = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // valid is deliberately not sampled here: the initiator sees ready on
      // this edge and needs it to present the next request.
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Array access happens on the RESP-entry edge only, so a reset that lands
  // earlier abandons the request without committing a write.
  assign mem_we = resp_enter && (wr_rd_q == WR);
  assign mem_re = resp_enter && (wr_rd_q == RD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_rd_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_rd_q <= wr_rd_d;
      ready_q <= ready_d;
    end
  end

  mem_array #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (bus.rdata)
  );

  assign bus.ready = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Scoreboard bench for mem_responder: one instance with WAIT_STATES=2 and
// one with WAIT_STATES=0. The driver pushes the expected rdata and the
// capture cycle of every request; a monitor per instance pops on each ready
// pulse and checks data, latency and pulse width.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [15:0] rdata;
    int          cap;
    int          id;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  int   req_id = 0;
  logic rdy_prev2 = 1'b0;
  logic rdy_prev0 = 1'b0;

  mem_responder_if if2 ();
  mem_responder_if if0 ();

  mem_responder #(.WAIT_STATES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, WAIT_STATES=2: ready expected 3 edges after the capture edge.
  always @(negedge clk) begin
    exp_t e;
    if (rdy_prev2 === 1'b1) begin
      checks++;
      if (if2.ready !== 1'b0) begin
        errors++;
        $display("FAIL ws2_ready_width: ready=%b on second cycle, required 0", if2.ready);
      end
    end
    rdy_prev2 = if2.ready;
    if (if2.ready === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL ws2_unexpected_ready: ready=1 at cycle %0d with no request outstanding", cyc);
      end else begin
        e = q2.pop_front();
        if (if2.rdata !== e.rdata) begin
          errors++;
          $display("FAIL ws2_rdata req%0d: rdata=%h, required %h", e.id, if2.rdata, e.rdata);
        end
        checks++;
        if (cyc != e.cap + 3) begin
          errors++;
          $display("FAIL ws2_latency req%0d: ready at edge %0d, required edge %0d", e.id, cyc, e.cap + 3);
        end
      end
    end
  end

  // Monitor, WAIT_STATES=0: ready expected 1 edge after the capture edge.
  always @(negedge clk) begin
    exp_t e;
    if (rdy_prev0 === 1'b1) begin
      checks++;
      if (if0.ready !== 1'b0) begin
        errors++;
        $display("FAIL ws0_ready_width: ready=%b on second cycle, required 0", if0.ready);
      end
    end
    rdy_prev0 = if0.ready;
    if (if0.ready === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL ws0_unexpected_ready: ready=1 at cycle %0d with no request outstanding", cyc);
      end else begin
        e = q0.pop_front();
        if (if0.rdata !== e.rdata) begin
          errors++;
          $display("FAIL ws0_rdata req%0d: rdata=%h, required %h", e.id, if0.rdata, e.rdata);
        end
        checks++;
        if (cyc != e.cap + 1) begin
          errors++;
          $display("FAIL ws0_latency req%0d: ready at edge %0d, required edge %0d", e.id, cyc, e.cap + 1);
        end
      end
    end
  end

  task automatic drive(input bit d0, input logic v, input logic wr,
                       input logic [7:0] a, input logic [15:0] wd);
    if (d0) begin
      if0.valid = v; if0.wr_rd = wr; if0.addr = a; if0.wdata = wd;
    end else begin
      if2.valid = v; if2.wr_rd = wr; if2.addr = a; if2.wdata = wd;
    end
  endtask

  function automatic logic rdy(input bit d0);
    return d0 ? if0.ready : if2.ready;
  endfunction

  // Called at a negedge: the request is captured on the next posedge.
  task automatic push(input bit d0, input logic [15:0] exp_rd);
    exp_t e;
    e.rdata = exp_rd;
    e.cap   = cyc + 1;
    e.id    = req_id;
    req_id++;
    if (d0) q0.push_back(e);
    else    q2.push_back(e);
  endtask

  task automatic wait_ready(input bit d0);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy(d0) !== 1'b1 && n < 40);
    if (rdy(d0) !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: ready=%b after 40 cycles, required 1", d0 ? 0 : 2, rdy(d0));
    end
  endtask

  // One transfer: present, wait for ready, step past the RESP edge; the next
  // request (if any) is then captured on the following edge.
  task automatic req(input bit d0, input logic wr, input logic [7:0] a,
                     input logic [15:0] wd, input logic [15:0] exp_rd, input bit hold);
    drive(d0, 1'b1, wr, a, wd);
    push(d0, exp_rd);
    wait_ready(d0);
    @(negedge clk);
    if (!hold) drive(d0, 1'b0, wr, a, wd);
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] rd2, input logic [15:0] rd0);
    checks++;
    if (if2.ready !== 1'b0 || if2.rdata !== rd2) begin
      errors++;
      $display("FAIL %s ws2: ready=%b rdata=%h, required ready=0 rdata=%h", tag, if2.ready, if2.rdata, rd2);
    end
    checks++;
    if (if0.ready !== 1'b0 || if0.rdata !== rd0) begin
      errors++;
      $display("FAIL %s ws0: ready=%b rdata=%h, required ready=0 rdata=%h", tag, if0.ready, if0.rdata, rd0);
    end
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b1, 8'h33, 16'h7777);
    drive(1'b1, 1'b1, 1'b1, 8'h33, 16'h7777);
    rst = 1'b0;

    // Reset held with valid high: nothing captured, outputs cleared.
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset_hold", 16'h0000, 16'h0000);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("post_reset_idle", 16'h0000, 16'h0000);

    // Write then read, WAIT_STATES=2.
    req(1'b0, 1'b1, 8'h10, 16'hA5A5, 16'h0000, 1'b0);
    @(negedge clk);
    req(1'b0, 1'b0, 8'h10, 16'h0000, 16'hA5A5, 1'b0);
    @(negedge clk);

    // Back-to-back with valid held throughout.
    req(1'b0, 1'b1, 8'h00, 16'h1111, 16'hA5A5, 1'b1);
    req(1'b0, 1'b1, 8'hFF, 16'h2222, 16'hA5A5, 1'b1);
    req(1'b0, 1'b0, 8'h00, 16'h0000, 16'h1111, 1'b1);
    req(1'b0, 1'b0, 8'hFF, 16'h0000, 16'h2222, 1'b0);
    @(negedge clk);

    // Reset during WAIT abandons a write of 0xBEEF over 0x1234.
    req(1'b0, 1'b1, 8'h20, 16'h1234, 16'h2222, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h20, 16'hBEEF);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset_mid_wait", 16'h0000, 16'h0000);
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk_idle("after_abandon", 16'h0000, 16'h0000);
    end
    req(1'b0, 1'b0, 8'h20, 16'h0000, 16'h1234, 1'b0);
    @(negedge clk);

    // Inputs changed and valid dropped after capture: the captured read wins.
    req(1'b0, 1'b1, 8'h11, 16'h5A5A, 16'h1234, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    push(1'b0, 16'hA5A5);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 8'h11, 16'hFFFF);
    wait_ready(1'b0);
    @(negedge clk);
    @(negedge clk);

    // WAIT_STATES=0: write and back-to-back reads.
    req(1'b1, 1'b1, 8'h01, 16'h0055, 16'h0000, 1'b1);
    req(1'b1, 1'b0, 8'h01, 16'h0000, 16'h0055, 1'b1);
    req(1'b1, 1'b1, 8'h02, 16'h6666, 16'h0055, 1'b1);
    req(1'b1, 1'b0, 8'h02, 16'h0000, 16'h6666, 1'b0);

    repeat (6) @(negedge clk);
    checks++;
    if (q2.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL outstanding: %0d/%0d responses missing, required 0/0", q2.size(), q0.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
